// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, branch modes and
// next-PC selection codes.
package ex_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    // STOP is all ones so OR-ing a stop mask onto any code forces a PC hold.
    typedef enum logic [1:0] {
        PC_INC_NORMAL = 2'b00,
        PC_INC_BRANCH = 2'b01,
        PC_INC_JUMP   = 2'b10,
        PC_INC_STOP   = 2'b11
    } pc_inc_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/ex_alu_core.sv
// Combinational 32-bit ALU; undefined op codes return 0 so zero reads 1.
module ex_alu_core
    import ex_pkg::*;
(
    input  logic [3:0]  alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'h0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {31'b0, (a < b)};
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $signed(a) >>> b[4:0];
            ALU_LUI:  result = {b[15:0], 16'h0};
            default:  result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/ex_alu_pc_unit.sv
// Execute-stage ALU plus next-PC selection, with the ALU result, zero flag
// and next PC also registered for the EX/MEM latch and PC register.
module ex_alu_pc_unit
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  branch_mode,
    input  logic [1:0]  pc_inc,
    input  logic [31:0] last_pc,
    input  logic [31:0] abs_addr,
    input  logic [31:0] branch_addr,
    output logic [31:0] result,
    output logic        zero,
    output logic [31:0] next_pc,
    output logic [1:0]  pc_inc_eff,
    output logic [31:0] alu_result_q,
    output logic        alu_zero_q,
    output logic [31:0] next_pc_q
);

    logic        taken;
    logic [31:0] pc4;
    logic [31:0] branch_target;

    ex_alu_core u_alu_core (
        .alu_op (alu_op),
        .a      (a),
        .b      (b),
        .result (result),
        .zero   (zero)
    );

    always_comb begin
        taken = 1'b0;
        case (branch_mode)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = !zero;
            default: taken = 1'b0;
        endcase
    end

    // branch_addr is a word offset; shifting drops its top two bits by design.
    assign pc4           = last_pc + PC_STEP;
    assign branch_target = pc4 + (branch_addr << 2);

    always_comb begin
        next_pc    = pc4;
        pc_inc_eff = pc_inc;
        if (clr) begin
            next_pc    = 32'h0;
            pc_inc_eff = PC_INC_NORMAL;
        end else begin
            case (pc_inc_e'(pc_inc))
                PC_INC_NORMAL: next_pc = pc4;
                PC_INC_BRANCH: next_pc = taken ? branch_target : pc4;
                PC_INC_JUMP:   next_pc = abs_addr;
                PC_INC_STOP:   next_pc = last_pc;
                default:       next_pc = pc4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            alu_result_q <= 32'h0;
            alu_zero_q   <= 1'b0;
            next_pc_q    <= 32'h0;
        end else begin
            alu_result_q <= result;
            alu_zero_q   <= zero;
            next_pc_q    <= next_pc;
        end
    end

endmodule

// File: tb/tb_ex_alu_pc_unit.sv
// Directed-vector bench: the driver pushes hand-computed expectations into a
// queue and a monitor pops and compares them just after each rising edge.
module tb_ex_alu_pc_unit;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  alu_op;
    logic [31:0] a, b;
    logic [1:0]  branch_mode, pc_inc;
    logic [31:0] last_pc, abs_addr, branch_addr;
    logic [31:0] result, next_pc, alu_result_q, next_pc_q;
    logic        zero, alu_zero_q;
    logic [1:0]  pc_inc_eff;

    int total = 0;
    int bad   = 0;

    ex_alu_pc_unit dut (
        .clk          (clk),
        .clr          (clr),
        .alu_op       (alu_op),
        .a            (a),
        .b            (b),
        .branch_mode  (branch_mode),
        .pc_inc       (pc_inc),
        .last_pc      (last_pc),
        .abs_addr     (abs_addr),
        .branch_addr  (branch_addr),
        .result       (result),
        .zero         (zero),
        .next_pc      (next_pc),
        .pc_inc_eff   (pc_inc_eff),
        .alu_result_q (alu_result_q),
        .alu_zero_q   (alu_zero_q),
        .next_pc_q    (next_pc_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        clr;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  bm;
        logic [1:0]  pinc;
        logic [31:0] lp;
        logic [31:0] abs_a;
        logic [31:0] br;
        logic [31:0] res;
        logic        z;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        z;
        logic [31:0] pc;
        logic [1:0]  pinc;
        logic [31:0] qres;
        logic        qz;
        logic [31:0] qpc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string nm, logic c, logic [3:0] op, logic [31:0] va, logic [31:0] vb,
                                logic [1:0] bm, logic [1:0] pinc, logic [31:0] lp, logic [31:0] ab,
                                logic [31:0] br, logic [31:0] res, logic z, logic [31:0] pc);
        vec_t v;
        v.nm = nm; v.clr = c; v.op = op; v.a = va; v.b = vb; v.bm = bm; v.pinc = pinc;
        v.lp = lp; v.abs_a = ab; v.br = br; v.res = res; v.z = z; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got=0x%08h want=0x%08h", nm, field, act, exp);
        end
    endtask

    // Monitor: outputs are stable between the edge and the next negedge drive.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "result",       result,                e.res);
                chk(e.nm, "zero",         {31'b0, zero},         {31'b0, e.z});
                chk(e.nm, "next_pc",      next_pc,               e.pc);
                chk(e.nm, "pc_inc_eff",   {30'b0, pc_inc_eff},   {30'b0, e.pinc});
                chk(e.nm, "alu_result_q", alu_result_q,          e.qres);
                chk(e.nm, "alu_zero_q",   {31'b0, alu_zero_q},   {31'b0, e.qz});
                chk(e.nm, "next_pc_q",    next_pc_q,             e.qpc);
            end
        end
    end

    initial begin
        exp_t e;
        int   waited;
        clr = 1'b1; alu_op = ALU_ADD; a = '0; b = '0; branch_mode = BR_NONE;
        pc_inc = PC_INC_NORMAL; last_pc = '0; abs_addr = '0; branch_addr = '0;

        //             name        clr op        a             b             bm       pinc           last_pc       abs           br            result        z     next_pc
        vecs.push_back(mk("reset",  1, ALU_ADD,  32'h0,        32'h0,        BR_NONE, PC_INC_JUMP,   32'h1000,     32'h400,      32'h0,        32'h0,        1'b1, 32'h0));
        vecs.push_back(mk("add_ovf",0, ALU_ADD,  32'h7FFFFFFF, 32'h1,        BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h80000000, 1'b0, 32'h1004));
        vecs.push_back(mk("sub_eq", 0, ALU_SUB,  32'h5,        32'h5,        BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h0,        1'b1, 32'h1004));
        vecs.push_back(mk("nor",    0, ALU_NOR,  32'h0,        32'h0,        BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'h1004));
        vecs.push_back(mk("slt",    0, ALU_SLT,  32'hFFFFFFFF, 32'h1,        BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h1,        1'b0, 32'h1004));
        vecs.push_back(mk("sltu",   0, ALU_SLTU, 32'hFFFFFFFF, 32'h1,        BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h0,        1'b1, 32'h1004));
        vecs.push_back(mk("sra",    0, ALU_SRA,  32'h80000000, 32'h4,        BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'hF8000000, 1'b0, 32'h1004));
        vecs.push_back(mk("srl",    0, ALU_SRL,  32'h80000000, 32'h4,        BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h08000000, 1'b0, 32'h1004));
        vecs.push_back(mk("lui",    0, ALU_LUI,  32'h0000DEAD, 32'hABCD1234, BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h12340000, 1'b0, 32'h1004));
        vecs.push_back(mk("and",    0, ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'hF000F000, 1'b0, 32'h1004));
        vecs.push_back(mk("or",     0, ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'hFFF0FFF0, 1'b0, 32'h1004));
        vecs.push_back(mk("xor",    0, ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h0FF00FF0, 1'b0, 32'h1004));
        vecs.push_back(mk("sll_b5", 0, ALU_SLL,  32'h1,        32'h21,       BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h2,        1'b0, 32'h1004));
        vecs.push_back(mk("op12",   0, 4'd12,    32'h5,        32'h5,        BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h0,        1'b1, 32'h1004));
        vecs.push_back(mk("beq_t",  0, ALU_SUB,  32'h3,        32'h3,        BR_BEQ,  PC_INC_BRANCH, 32'h100,      32'h0,        32'hFFFFFFFF, 32'h0,        1'b1, 32'h100));
        vecs.push_back(mk("beq_nt", 0, ALU_SUB,  32'h4,        32'h3,        BR_BEQ,  PC_INC_BRANCH, 32'h100,      32'h0,        32'hFFFFFFFF, 32'h1,        1'b0, 32'h104));
        vecs.push_back(mk("bne_t",  0, ALU_SUB,  32'h4,        32'h3,        BR_BNE,  PC_INC_BRANCH, 32'h100,      32'h0,        32'hFFFFFFFF, 32'h1,        1'b0, 32'h100));
        vecs.push_back(mk("br11",   0, ALU_SUB,  32'h3,        32'h3,        2'b11,   PC_INC_BRANCH, 32'h100,      32'h0,        32'hFFFFFFFF, 32'h0,        1'b1, 32'h104));
        vecs.push_back(mk("beq_fw", 0, ALU_SUB,  32'h3,        32'h3,        BR_BEQ,  PC_INC_BRANCH, 32'h100,      32'h0,        32'h10,       32'h0,        1'b1, 32'h144));
        vecs.push_back(mk("jump",   0, ALU_ADD,  32'h2,        32'h3,        BR_BEQ,  PC_INC_JUMP,   32'h100,      32'h00400020, 32'h0,        32'h5,        1'b0, 32'h00400020));
        vecs.push_back(mk("stop",   0, 4'd15,    32'h2,        32'h3,        BR_NONE, PC_INC_STOP,   32'h200,      32'h0,        32'h0,        32'h0,        1'b1, 32'h200));
        vecs.push_back(mk("wrap",   0, ALU_ADD,  32'h2,        32'h3,        BR_NONE, PC_INC_NORMAL, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h5,        1'b0, 32'h0));
        vecs.push_back(mk("clr_mid",1, ALU_ADD,  32'h2,        32'h3,        BR_BNE,  PC_INC_JUMP,   32'h300,      32'h00400020, 32'h0,        32'h5,        1'b0, 32'h0));
        vecs.push_back(mk("clr_hld",1, ALU_NOR,  32'h0,        32'h0,        BR_NONE, PC_INC_STOP,   32'h300,      32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'h0));
        vecs.push_back(mk("resume", 0, ALU_ADD,  32'h2,        32'h3,        BR_NONE, PC_INC_NORMAL, 32'h1000,     32'h0,        32'h0,        32'h5,        1'b0, 32'h1004));
        vecs.push_back(mk("tail",   0, ALU_SUB,  32'h9,        32'h9,        BR_BNE,  PC_INC_BRANCH, 32'h2000,     32'h0,        32'h8,        32'h0,        1'b1, 32'h2004));

        foreach (vecs[i]) begin
            @(negedge clk);
            clr = vecs[i].clr; alu_op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            branch_mode = vecs[i].bm; pc_inc = vecs[i].pinc; last_pc = vecs[i].lp;
            abs_addr = vecs[i].abs_a; branch_addr = vecs[i].br;
            e.nm   = vecs[i].nm;
            e.res  = vecs[i].res;
            e.z    = vecs[i].z;
            e.pc   = vecs[i].pc;
            e.pinc = vecs[i].clr ? 2'b00 : vecs[i].pinc;
            e.qres = vecs[i].clr ? 32'h0 : vecs[i].res;
            e.qz   = vecs[i].clr ? 1'b0  : vecs[i].z;
            e.qpc  = vecs[i].clr ? 32'h0 : vecs[i].pc;
            sb.push_back(e);
        end

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
